// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants, status bit indices and FSM states
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  // 0x04C11DB7 bit-reversed, for the LSB-first shift
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  localparam int STAT_CRC_ERR  = 0;
  localparam int STAT_RUNT     = 1;
  localparam int STAT_GIANT    = 2;
  localparam int STAT_MAC_MISS = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    BODY,
    DONE,
    DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC-32 next state for one data byte
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// rtl/gmii_rx_frame.sv - GMII receive framer: preamble strip, FCS strip, CRC/length/MAC checks
module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rec_data,
  output logic        rec_en,
  output logic        rec_sof,
  output logic        rec_eof,
  output logic [10:0] rec_byte_num,
  output logic [3:0]  rec_status,
  output logic        rec_good
);

  localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME);
  localparam logic [10:0] TOTAL_SAT = 11'(MAX_FRAME + 1);

  rx_state_t   state;
  logic [2:0]  pre_cnt;
  logic [10:0] total;
  logic [10:0] total_inc;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] dline;
  logic        mac_local_ok;
  logic        mac_bcast_ok;
  logic [7:0]  mac_byte;
  logic [3:0]  frame_status;
  logic [10:0] byte_num;

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc),
    .data    (gmii_rxd),
    .crc_out (crc_next)
  );

  always_comb begin
    total_inc = (total == TOTAL_SAT) ? total : total + 11'd1;

    mac_byte = 8'h00;
    case (total[2:0])
      3'd0:    mac_byte = BOARD_MAC[47:40];
      3'd1:    mac_byte = BOARD_MAC[39:32];
      3'd2:    mac_byte = BOARD_MAC[31:24];
      3'd3:    mac_byte = BOARD_MAC[23:16];
      3'd4:    mac_byte = BOARD_MAC[15:8];
      3'd5:    mac_byte = BOARD_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase

    // fewer than four bytes cannot hold an FCS, so the CRC is never trusted
    frame_status                = '0;
    frame_status[STAT_CRC_ERR]  = (total < 11'd4) || (crc != CRC32_RESIDUE);
    frame_status[STAT_RUNT]     = (total < MIN_LEN);
    frame_status[STAT_GIANT]    = (total > MAX_LEN);
    frame_status[STAT_MAC_MISS] = (total < 11'd6) || !(mac_local_ok || mac_bcast_ok);

    byte_num = (total >= 11'd4) ? total - 11'd4 : 11'd0;
  end

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state        <= DROP;
      pre_cnt      <= 3'd0;
      total        <= 11'd0;
      crc          <= CRC32_INIT;
      dline        <= 32'd0;
      mac_local_ok <= 1'b1;
      mac_bcast_ok <= 1'b1;
      rec_data     <= 8'h00;
      rec_en       <= 1'b0;
      rec_sof      <= 1'b0;
      rec_eof      <= 1'b0;
      rec_byte_num <= 11'd0;
      rec_status   <= 4'd0;
      rec_good     <= 1'b0;
    end else begin
      rec_en       <= 1'b0;
      rec_sof      <= 1'b0;
      rec_eof      <= 1'b0;
      rec_good     <= 1'b0;
      rec_byte_num <= 11'd0;
      rec_status   <= 4'd0;

      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            total        <= 11'd0;
            crc          <= CRC32_INIT;
            dline        <= 32'd0;
            mac_local_ok <= 1'b1;
            mac_bcast_ok <= 1'b1;
          end
          // a preamble byte may already arrive in the DONE cycle after a one-cycle gap
          if (gmii_rx_dv) begin
            if (gmii_rxd == ETH_PREAMBLE) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= DROP;
            end
          end else begin
            state <= IDLE;
          end
        end

        PRE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rxd == ETH_PREAMBLE) begin
            if (pre_cnt == 3'd7) begin
              state <= DROP;
            end else begin
              pre_cnt <= pre_cnt + 3'd1;
            end
          end else if (gmii_rxd == ETH_SFD) begin
            state <= BODY;
          end else begin
            state <= DROP;
          end
        end

        BODY: begin
          if (gmii_rx_dv) begin
            dline <= {dline[23:0], gmii_rxd};
            crc   <= crc_next;
            total <= total_inc;
            if (total < 11'd6) begin
              if (gmii_rxd != mac_byte) mac_local_ok <= 1'b0;
              if (gmii_rxd != 8'hFF)    mac_bcast_ok <= 1'b0;
            end
            // the oldest of four held bytes leaves; the last four (FCS) never do
            if (total >= 11'd4) begin
              rec_data <= dline[31:24];
              rec_en   <= (total_inc <= MAX_LEN);
              rec_sof  <= (total == 11'd4);
            end
          end else begin
            state        <= DONE;
            rec_eof      <= 1'b1;
            rec_status   <= frame_status;
            rec_byte_num <= byte_num;
            rec_good     <= (frame_status == 4'd0);
          end
        end

        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end

        default: state <= DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb/tb_gmii_rx_frame.sv - randomized self-checking bench for gmii_rx_frame against a frame-level model
module tb_gmii_rx_frame;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  rxd;
  logic [7:0]  rec_data;
  logic        rec_en;
  logic        rec_sof;
  logic        rec_eof;
  logic [10:0] rec_byte_num;
  logic [3:0]  rec_status;
  logic        rec_good;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  got_q[$];
  int          sof_cnt;
  int          sof_bad;
  logic [7:0]  sof_byte;
  int          eof_cnt;
  int          overlap;
  logic [10:0] eof_num;
  logic [3:0]  eof_stat;
  logic        eof_good;

  gmii_rx_frame #(
    .BOARD_MAC (BOARD_MAC),
    .MIN_FRAME (MIN_FRAME),
    .MAX_FRAME (MAX_FRAME)
  ) dut (
    .gmii_rx_clk  (clk),
    .rst          (rst),
    .gmii_rx_dv   (dv),
    .gmii_rxd     (rxd),
    .rec_data     (rec_data),
    .rec_en       (rec_en),
    .rec_sof      (rec_sof),
    .rec_eof      (rec_eof),
    .rec_byte_num (rec_byte_num),
    .rec_status   (rec_status),
    .rec_good     (rec_good)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rec_en) got_q.push_back(rec_data);
    if (rec_sof) begin
      sof_cnt++;
      sof_byte = rec_data;
      if (!rec_en) sof_bad++;
    end
    if (rec_eof) begin
      eof_cnt++;
      eof_num  = rec_byte_num;
      eof_stat = rec_status;
      eof_good = rec_good;
      if (rec_en) overlap++;
    end
  end

  task automatic clr();
    got_q.delete();
    sof_cnt = 0;
    sof_bad = 0;
    eof_cnt = 0;
    overlap = 0;
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk);
    dv  = v;
    rxd = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  function automatic logic [31:0] crc32_ref(input bq_t d, input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'd0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_frame(input logic [47:0] da, input int plen);
    bq_t q;
    logic [31:0] fcs;
    for (int i = 5; i >= 0; i--) q.push_back(da[8*i +: 8]);
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom_range(0, 255)));
    fcs = crc32_ref(q, q.size());
    for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
    return q;
  endfunction

  task automatic send_frame(input int pre_len, input bq_t body, input int gap);
    for (int i = 0; i < pre_len; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    foreach (body[i]) drive(1'b1, body[i]);
    idle(gap);
  endtask

  task automatic check_frame(input string tag, input bq_t body, input int exp_eof);
    int n, fwd, nmatch;
    logic [47:0] da;
    logic [31:0] fcs;
    logic [3:0]  st;
    n = body.size();
    check({tag, "_eof_cnt"}, eof_cnt, exp_eof);
    if (exp_eof == 0) begin
      check({tag, "_nbytes"}, got_q.size(), 0);
      return;
    end
    fwd = (n < 4) ? 0 : (((n > MAX_FRAME) ? MAX_FRAME : n) - 4);
    st = 4'd0;
    if (n < 4) begin
      st[0] = 1'b1;
    end else begin
      fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
      st[0] = (crc32_ref(body, n - 4) != fcs);
    end
    st[1] = (n < MIN_FRAME);
    st[2] = (n > MAX_FRAME);
    if (n < 6) begin
      st[3] = 1'b1;
    end else begin
      da = {body[0], body[1], body[2], body[3], body[4], body[5]};
      st[3] = (da != BOARD_MAC) && (da != 48'hFFFF_FFFF_FFFF);
    end
    check({tag, "_byte_num"}, eof_num, (n > MAX_FRAME) ? MAX_FRAME + 1 - 4 : ((n >= 4) ? n - 4 : 0));
    check({tag, "_status"}, eof_stat, st);
    check({tag, "_good"}, eof_good, (st == 4'd0));
    check({tag, "_nbytes"}, got_q.size(), fwd);
    nmatch = 0;
    while (nmatch < fwd && nmatch < got_q.size() && got_q[nmatch] == body[nmatch]) nmatch++;
    check({tag, "_data_match"}, nmatch, fwd);
    check({tag, "_sof_cnt"}, sof_cnt, (fwd > 0) ? 1 : 0);
    check({tag, "_sof_with_en"}, sof_bad, 0);
    if (fwd > 0) check({tag, "_sof_data"}, sof_byte, body[0]);
    check({tag, "_eof_no_en"}, overlap, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, rec_data, 0);
    check({tag, "_en"}, rec_en, 0);
    check({tag, "_sof"}, rec_sof, 0);
    check({tag, "_eof"}, rec_eof, 0);
    check({tag, "_num"}, rec_byte_num, 0);
    check({tag, "_status"}, rec_status, 0);
    check({tag, "_good"}, rec_good, 0);
  endtask

  initial begin
    bq_t f, empty;
    logic [47:0] da;
    int plen, sel;

    rst = 1'b1;
    dv  = 1'b0;
    rxd = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(3);

    clr();
    f = make_frame(BOARD_MAC, 54);
    send_frame(7, f, 1);
    idle(3);
    check_frame("good64", f, 1);

    clr();
    f[60] = f[60] ^ 8'h01;
    send_frame(7, f, 1);
    idle(3);
    check_frame("badfcs", f, 1);

    clr();
    f = make_frame(48'hFFFF_FFFF_FFFF, 50);
    send_frame(7, f, 1);
    idle(3);
    check_frame("bcast60", f, 1);

    clr();
    f = make_frame(48'h02_00_00_00_00_01, 50);
    send_frame(7, f, 1);
    idle(3);
    check_frame("miss60", f, 1);

    clr();
    f = make_frame(BOARD_MAC, 1590);
    send_frame(7, f, 1);
    idle(3);
    check_frame("giant", f, 1);

    clr();
    repeat (3) drive(1'b1, 8'h55);
    idle(1);
    f = make_frame(BOARD_MAC, 54);
    send_frame(7, f, 1);
    idle(3);
    check_frame("pre_abort", f, 1);

    clr();
    f = make_frame(BOARD_MAC, 54);
    send_frame(8, f, 1);
    idle(3);
    check_frame("long_pre", empty, 0);

    clr();
    f = make_frame(BOARD_MAC, 90);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, f[i]);
    @(negedge clk);
    rst = 1'b1;
    dv  = 1'b1;
    rxd = f[30];
    #1;
    check_outputs_zero("rst_mid");
    clr();
    drive(1'b1, f[31]);
    drive(1'b1, f[32]);
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b1;
    rxd = f[33];
    for (int i = 34; i < f.size(); i++) drive(1'b1, f[i]);
    idle(4);
    check_frame("rst_tail", empty, 0);

    clr();
    f = make_frame(BOARD_MAC, 60);
    send_frame(7, f, 1);
    idle(3);
    check_frame("after_rst", f, 1);

    for (int it = 0; it < 30; it++) begin
      clr();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       da = BOARD_MAC;
        1:       da = 48'hFFFF_FFFF_FFFF;
        2:       da = BOARD_MAC ^ (48'd1 << $urandom_range(0, 47));
        default: da = {$urandom(), 16'($urandom())};
      endcase
      if ($urandom_range(0, 4) == 0) begin
        f.delete();
        plen = $urandom_range(0, 8);
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom_range(0, 255)));
      end else begin
        plen = ($urandom_range(0, 1) == 0) ? $urandom_range(40, 70) : $urandom_range(0, 200);
        f = make_frame(da, plen);
        if ($urandom_range(0, 3) == 0) begin
          sel = $urandom_range(0, f.size() - 1);
          f[sel] = f[sel] ^ (8'd1 << $urandom_range(0, 7));
        end
      end
      send_frame($urandom_range(1, 7), f, $urandom_range(1, 3));
      idle(3);
      check_frame($sformatf("rand%0d", it), f, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
